// File: rtl/comparator_arbiter_if.sv
// Bundle of requester, result and external-comparator signals for comparator_arbiter.
// The arbiter connects through the slave modport; the requester/comparator side uses master.
interface comparator_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REQ_NUMBER = 4
);
  logic [REQ_NUMBER-1:0]            req_i;
  logic [REQ_NUMBER*DATA_WIDTH-1:0] data_0_i;
  logic [REQ_NUMBER*DATA_WIDTH-1:0] data_1_i;
  logic [REQ_NUMBER-1:0]            gnt_o;
  logic [REQ_NUMBER-1:0]            done_o;
  logic                             equal_o;
  logic                             greater_o;
  logic                             lower_o;
  logic                             busy_o;
  logic                             error_o;
  logic [DATA_WIDTH-1:0]            cmp_data_0_o;
  logic [DATA_WIDTH-1:0]            cmp_data_1_o;
  logic                             cmp_equal_i;
  logic                             cmp_greater_i;
  logic                             cmp_lower_i;

  modport slave (
    input  req_i, data_0_i, data_1_i, cmp_equal_i, cmp_greater_i, cmp_lower_i,
    output gnt_o, done_o, equal_o, greater_o, lower_o, busy_o, error_o,
           cmp_data_0_o, cmp_data_1_o
  );

  modport master (
    output req_i, data_0_i, data_1_i, cmp_equal_i, cmp_greater_i, cmp_lower_i,
    input  gnt_o, done_o, equal_o, greater_o, lower_o, busy_o, error_o,
           cmp_data_0_o, cmp_data_1_o
  );
endinterface

// File: rtl/comparator_arbiter.sv
// Round-robin arbiter that latches one requester's operands, lets an external
// comparator settle, then captures and returns its result to that requester.
//
// state  | meaning
// IDLE   | waiting for any request; grants and latches operands
// SETTLE | operands held on comparator, counting down settle time
// DONE   | result delivered; one cycle for the requester to drop req
module comparator_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int REQ_NUMBER    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input logic clk_i,
  input logic a_rst_n_i,
  comparator_arbiter_if.slave bus
);
  localparam int PTR_W = (REQ_NUMBER > 1) ? $clog2(REQ_NUMBER) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PTR_W-1:0]      PTR_RST  = PTR_W'(REQ_NUMBER - 1);
  localparam logic [REQ_NUMBER-1:0] ONE      = REQ_NUMBER'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        ptr, ptr_nxt, sel, cand;
  logic                    sel_vld;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [REQ_NUMBER-1:0]   gnt_nxt, done_nxt;
  logic [DATA_WIDTH-1:0]   d0_nxt, d1_nxt;
  logic                    eq_nxt, gt_nxt, lt_nxt, err_nxt;
  logic                    res_onehot;

  // Lowest offset from ptr+1 wins, so the loop runs downward and the last hit sticks.
  always_comb begin
    sel     = ptr;
    sel_vld = 1'b0;
    cand    = ptr;
    for (int i = REQ_NUMBER; i >= 1; i--) begin
      cand = PTR_W'((int'(ptr) + i) % REQ_NUMBER);
      if (bus.req_i[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  assign res_onehot = {bus.cmp_equal_i, bus.cmp_greater_i, bus.cmp_lower_i}
                      inside {3'b100, 3'b010, 3'b001};

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = '0;
    done_nxt  = '0;
    d0_nxt    = bus.cmp_data_0_o;
    d1_nxt    = bus.cmp_data_1_o;
    eq_nxt    = bus.equal_o;
    gt_nxt    = bus.greater_o;
    lt_nxt    = bus.lower_o;
    err_nxt   = bus.error_o;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt = SETTLE;
          ptr_nxt   = sel;
          cnt_nxt   = CNT_LOAD;
          gnt_nxt   = ONE << sel;
          d0_nxt    = bus.data_0_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
          d1_nxt    = bus.data_1_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          done_nxt  = ONE << ptr;
          eq_nxt    = bus.cmp_equal_i;
          gt_nxt    = bus.cmp_greater_i;
          lt_nxt    = bus.cmp_lower_i;
          err_nxt   = bus.error_o | ~res_onehot;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state            <= IDLE;
      ptr              <= PTR_RST;
      cnt              <= '0;
      bus.gnt_o        <= '0;
      bus.done_o       <= '0;
      bus.cmp_data_0_o <= '0;
      bus.cmp_data_1_o <= '0;
      bus.equal_o      <= 1'b0;
      bus.greater_o    <= 1'b0;
      bus.lower_o      <= 1'b0;
      bus.error_o      <= 1'b0;
    end else begin
      state            <= state_nxt;
      ptr              <= ptr_nxt;
      cnt              <= cnt_nxt;
      bus.gnt_o        <= gnt_nxt;
      bus.done_o       <= done_nxt;
      bus.cmp_data_0_o <= d0_nxt;
      bus.cmp_data_1_o <= d1_nxt;
      bus.equal_o      <= eq_nxt;
      bus.greater_o    <= gt_nxt;
      bus.lower_o      <= lt_nxt;
      bus.error_o      <= err_nxt;
    end
  end

  assign bus.busy_o = (state != IDLE);
endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed bench for comparator_arbiter: vector table of single requests plus
// sequences for reset, fairness and reset during settle.
module tb_comparator_arbiter;
  localparam int DW = 32;
  localparam int RN = 4;

  logic clk_i = 1'b0;
  logic a_rst_n_i;
  logic fault;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  comparator_arbiter_if #(.DATA_WIDTH(DW), .REQ_NUMBER(RN)) bus ();

  comparator_arbiter #(.DATA_WIDTH(DW), .REQ_NUMBER(RN), .SETTLE_CYCLES(1)) dut (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .bus       (bus)
  );

  // External comparator (unsigned), with a fault mode giving a non-one-hot answer.
  assign bus.cmp_equal_i   = fault ? 1'b0 : (bus.cmp_data_0_o == bus.cmp_data_1_o);
  assign bus.cmp_greater_i = fault ? 1'b1 : (bus.cmp_data_0_o >  bus.cmp_data_1_o);
  assign bus.cmp_lower_i   = fault ? 1'b1 : (bus.cmp_data_0_o <  bus.cmp_data_1_o);

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [RN-1:0] req;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          flt;
    logic          eq;
    logic          gt;
    logic          lt;
    logic          err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fill_data();
    for (int j = 0; j < RN; j++) begin
      bus.data_0_i[j*DW +: DW] = 32'hA5A5_0000 + j;
      bus.data_1_i[j*DW +: DW] = 32'h5A5A_0000 + j;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    a_rst_n_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    a_rst_n_i = 1'b1;
  endtask

  task automatic wait_gnt(output logic [RN-1:0] g, output int at);
    g  = '0;
    at = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_i);
      if (bus.gnt_o != '0) begin
        g  = bus.gnt_o;
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: got no grant within 10 cycles expected a grant");
    end
  endtask

  task automatic serve(input vec_t v);
    int k;
    k = 0;
    for (int j = 0; j < RN; j++) if (v.req[j]) k = j;
    fault = v.flt;
    @(negedge clk_i);
    fill_data();
    bus.data_0_i[k*DW +: DW] = v.a;
    bus.data_1_i[k*DW +: DW] = v.b;
    bus.req_i = v.req;
    @(negedge clk_i);
    chk("gnt", bus.gnt_o, v.req);
    chk("done_in_gnt_cycle", bus.done_o, 0);
    chk("busy_settle", bus.busy_o, 1);
    chk("cmp_data_0", bus.cmp_data_0_o, v.a);
    chk("cmp_data_1", bus.cmp_data_1_o, v.b);
    // Drop request and scramble operands while the comparison is in flight.
    bus.req_i    = '0;
    bus.data_0_i = ~bus.data_0_i;
    bus.data_1_i = ~bus.data_1_i;
    @(negedge clk_i);
    chk("done", bus.done_o, v.req);
    chk("gnt_in_done_cycle", bus.gnt_o, 0);
    chk("equal", bus.equal_o, v.eq);
    chk("greater", bus.greater_o, v.gt);
    chk("lower", bus.lower_o, v.lt);
    chk("error", bus.error_o, v.err);
    chk("busy_done", bus.busy_o, 1);
    @(negedge clk_i);
    chk("busy_idle", bus.busy_o, 0);
    chk("done_cleared", bus.done_o, 0);
    chk("gnt_idle", bus.gnt_o, 0);
    chk("lower_held", bus.lower_o, v.lt);
    chk("cmp_data_0_held", bus.cmp_data_0_o, v.a);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"}, bus.gnt_o, 0);
    chk({nm, "_done"}, bus.done_o, 0);
    chk({nm, "_busy"}, bus.busy_o, 0);
    chk({nm, "_error"}, bus.error_o, 0);
    chk({nm, "_res"}, {bus.equal_o, bus.greater_o, bus.lower_o}, 0);
    chk({nm, "_cmp0"}, bus.cmp_data_0_o, 0);
    chk({nm, "_cmp1"}, bus.cmp_data_1_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RN-1:0] g;
    int at, prev;
    int order[4];

    vecs[0] = '{4'b0010, 32'd5,          32'd9,          1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{4'b0001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'b1000, 32'h8000_0000,  32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'b0100, 32'd0,          32'd0,          1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'b0001, 32'h7FFF_FFFF,  32'h8000_0000,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'b0100, 32'd12,         32'd12,         1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{4'b0010, 32'd3,          32'd1,          1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{4'b1000, 32'd1,          32'd1,          1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    fault        = 1'b0;
    bus.req_i    = '0;
    bus.data_0_i = '0;
    bus.data_1_i = '0;
    a_rst_n_i    = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_all_zero("reset");
    a_rst_n_i = 1'b1;

    // Reset asserted mid-cycle while busy clears outputs before any edge.
    @(negedge clk_i);
    fill_data();
    bus.req_i = 4'b0010;
    @(negedge clk_i);
    chk("pre_reset_gnt", bus.gnt_o, 4'b0010);
    #2 a_rst_n_i = 1'b0;
    #1 chk_all_zero("async_reset");
    bus.req_i = '0;
    @(negedge clk_i);
    a_rst_n_i = 1'b1;

    for (int i = 0; i < 8; i++) serve(vecs[i]);

    do_reset();
    fault = 1'b0;
    @(negedge clk_i);
    chk("error_cleared", bus.error_o, 0);

    // All four requesting, each drops after its done: order 0,1,2,3, 3 cycles apart.
    fill_data();
    bus.req_i = 4'b1111;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g, at);
      chk("rr_all_gnt", g, 4'b0001 << i);
      if (i > 0) chk("rr_all_spacing", at - prev, 3);
      prev = at;
      @(negedge clk_i);
      chk("rr_all_done", bus.done_o, 4'b0001 << i);
      bus.req_i[i] = 1'b0;
    end
    repeat (2) @(negedge clk_i);

    // req0 and req2 held continuously: grants alternate.
    do_reset();
    order = '{0, 2, 0, 2};
    bus.req_i = 4'b0101;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g, at);
      chk("rr_alt_gnt", g, 4'b0001 << order[i]);
      if (i > 0) chk("rr_alt_spacing", at - prev, 3);
      prev = at;
      @(negedge clk_i);
      chk("rr_alt_done", bus.done_o, 4'b0001 << order[i]);
    end
    bus.req_i = '0;
    repeat (2) @(negedge clk_i);

    // Reset during SETTLE discards the comparison.
    do_reset();
    fill_data();
    bus.req_i = 4'b0001;
    @(negedge clk_i);
    chk("settle_rst_gnt", bus.gnt_o, 4'b0001);
    a_rst_n_i = 1'b0;
    bus.req_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("settle_rst_no_done", bus.done_o, 0);
      chk("settle_rst_busy", bus.busy_o, 0);
      if (i == 1) a_rst_n_i = 1'b1;
    end
    serve(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
